// File: rtl/aes_key_expander.sv
// Iterative AES-128 key schedule: accepts one cipher key and streams
// round keys 0..10, sharing SUB_BYTES_PER_CYCLE S-box lookups per cycle.
package aes_model_pack;
    localparam logic [0:255][7:0] SUB_BYTES_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
    localparam logic [0:9][31:0] RCON_TABLE = {
        32'h01000000, 32'h02000000, 32'h04000000, 32'h08000000,
        32'h10000000, 32'h20000000, 32'h40000000, 32'h80000000,
        32'h1b000000, 32'h36000000
    };
endpackage

module aes_key_expander
    import aes_model_pack::*;
#(
    parameter int NUM_ROUNDS          = 10,
    parameter int SUB_BYTES_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy
);
    localparam int         SUB_CYCLES = 4 / SUB_BYTES_PER_CYCLE;
    localparam logic [1:0] LAST_SUB   = 2'(SUB_CYCLES - 1);
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    if (NUM_ROUNDS != 10) begin : g_bad_rounds
        $error("aes_key_expander: only NUM_ROUNDS = 10 is supported");
    end
    if (SUB_BYTES_PER_CYCLE != 1 && SUB_BYTES_PER_CYCLE != 2 &&
        SUB_BYTES_PER_CYCLE != 4) begin : g_bad_sub
        $error("aes_key_expander: SUB_BYTES_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        SUB
    } state_t;

    state_t           state_q, state_d;
    logic [127:0]     rk_q, rk_d;
    logic [3:0]       round_q, round_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [0:3][7:0]  temp_q, temp_d;

    logic [0:3][7:0]  rot;
    logic [7:0]       sb [SUB_BYTES_PER_CYCLE];
    logic [0:3][7:0]  sub_word;
    logic [31:0]      temp_f;
    logic [31:0]      w0_n, w1_n, w2_n, w3_n;

    assign rot = {rk_q[23:0], rk_q[31:24]};

    // Only SUB_BYTES_PER_CYCLE S-boxes exist; the byte counter steers them.
    always_comb begin : sbox_lookup
        for (int b = 0; b < SUB_BYTES_PER_CYCLE; b++) begin
            sb[b] = SUB_BYTES_TABLE[rot[2'(int'(cnt_q) * SUB_BYTES_PER_CYCLE + b)]];
        end
    end

    always_comb begin : sub_merge
        sub_word = temp_q;
        for (int j = 0; j < 4; j++) begin
            if (j / SUB_BYTES_PER_CYCLE == int'(cnt_q)) begin
                sub_word[j] = sb[j % SUB_BYTES_PER_CYCLE];
            end
        end
    end

    assign temp_f = sub_word ^ RCON_TABLE[round_q];
    assign w0_n   = rk_q[127:96] ^ temp_f;
    assign w1_n   = rk_q[95:64]  ^ w0_n;
    assign w2_n   = rk_q[63:32]  ^ w1_n;
    assign w3_n   = rk_q[31:0]   ^ w2_n;

    always_comb begin : next_state
        state_d = state_q;
        rk_d    = rk_q;
        round_d = round_q;
        cnt_d   = cnt_q;
        temp_d  = temp_q;
        unique case (state_q)
            IDLE: begin
                if (key_valid) begin
                    rk_d    = key_in;
                    round_d = 4'd0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (rk_ready) begin
                    if (round_q == LAST_ROUND) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = 2'd0;
                        state_d = SUB;
                    end
                end
            end
            SUB: begin
                temp_d = sub_word;
                if (cnt_q == LAST_SUB) begin
                    rk_d    = {w0_n, w1_n, w2_n, w3_n};
                    round_d = round_q + 4'd1;
                    state_d = EMIT;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rk_q    <= '0;
            round_q <= '0;
            cnt_q   <= '0;
            temp_q  <= '0;
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            round_q <= round_d;
            cnt_q   <= cnt_d;
            temp_q  <= temp_d;
        end
    end

    assign key_ready = (state_q == IDLE);
    assign rk_valid  = (state_q == EMIT);
    assign busy      = (state_q != IDLE);
    assign rk_out    = rk_q;
    assign rk_round  = round_q;
endmodule

// File: tb/tb_aes_key_expander.sv
// Bench for aes_key_expander: independent GF(2^8) key-schedule model,
// scoreboard of expected round keys, one task per scenario.
module tb_aes_key_expander;
    typedef logic [0:10][127:0] rks_t;
    typedef struct packed {
        logic [3:0]   r;
        logic [127:0] k;
    } exp_t;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [127:0] key_in1, rk_out1, key_in4, rk_out4;
    logic         key_valid1, key_ready1, rk_valid1, rk_ready1, busy1;
    logic         key_valid4, key_ready4, rk_valid4, rk_ready4, busy4;
    logic [3:0]   rk_round1, rk_round4;

    aes_key_expander #(.NUM_ROUNDS(10), .SUB_BYTES_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .key_in(key_in1), .key_valid(key_valid1),
        .key_ready(key_ready1), .rk_out(rk_out1), .rk_round(rk_round1),
        .rk_valid(rk_valid1), .rk_ready(rk_ready1), .busy(busy1)
    );

    aes_key_expander #(.NUM_ROUNDS(10), .SUB_BYTES_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .key_in(key_in4), .key_valid(key_valid4),
        .key_ready(key_ready4), .rk_out(rk_out4), .rk_round(rk_round4),
        .rk_valid(rk_valid4), .rk_ready(rk_ready4), .busy(busy4)
    );

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from the multiplicative inverse plus the affine transform
    function automatic logic [7:0] sbox_m(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic rks_t expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        rks_t        res;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m(t[31:24]), sbox_m(t[23:16]),
                     sbox_m(t[15:8]), sbox_m(t[7:0])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) res[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return res;
    endfunction

    exp_t         sb1[$], sb4[$];
    logic [127:0] got1[$], got4[$];
    int           hs1[$], hs4[$], acc1[$], acc4[$];
    rks_t         e1, e4;
    exp_t         x1, x4;
    logic         stall_p1 = 1'b0;
    logic [127:0] out_p1;
    logic [3:0]   rnd_p1;

    always @(negedge clk) begin
        if (rst) begin
            sb1.delete();
            stall_p1 = 1'b0;
        end else begin
            if (stall_p1) begin
                checks++;
                if (rk_valid1 !== 1'b1 || rk_out1 !== out_p1 || rk_round1 !== rnd_p1) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b round=%0d out=%h, want valid=1 round=%0d out=%h",
                             rk_valid1, rk_round1, rk_out1, rnd_p1, out_p1);
                end
            end
            stall_p1 = rk_valid1 && !rk_ready1;
            out_p1   = rk_out1;
            rnd_p1   = rk_round1;
            if (key_valid1 && key_ready1) begin
                e1 = expand(key_in1);
                for (int r = 0; r < 11; r++) sb1.push_back({4'(r), e1[r]});
                acc1.push_back(cyc + 1);
            end
            if (rk_valid1 && rk_ready1) begin
                got1.push_back(rk_out1);
                hs1.push_back(cyc + 1);
                checks++;
                if (sb1.size() == 0) begin
                    errors++;
                    $display("FAIL sb1_extra: round=%0d out=%h, want no output", rk_round1, rk_out1);
                end else begin
                    x1 = sb1.pop_front();
                    if (rk_round1 !== x1.r || rk_out1 !== x1.k) begin
                        errors++;
                        $display("FAIL sb1_key: round=%0d out=%h, want round=%0d out=%h",
                                 rk_round1, rk_out1, x1.r, x1.k);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            sb4.delete();
        end else begin
            if (key_valid4 && key_ready4) begin
                e4 = expand(key_in4);
                for (int r = 0; r < 11; r++) sb4.push_back({4'(r), e4[r]});
                acc4.push_back(cyc + 1);
            end
            if (rk_valid4 && rk_ready4) begin
                got4.push_back(rk_out4);
                hs4.push_back(cyc + 1);
                checks++;
                if (sb4.size() == 0) begin
                    errors++;
                    $display("FAIL sb4_extra: round=%0d out=%h, want no output", rk_round4, rk_out4);
                end else begin
                    x4 = sb4.pop_front();
                    if (rk_round4 !== x4.r || rk_out4 !== x4.k) begin
                        errors++;
                        $display("FAIL sb4_key: round=%0d out=%h, want round=%0d out=%h",
                                 rk_round4, rk_out4, x4.r, x4.k);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear1();
        got1.delete();
        hs1.delete();
        acc1.delete();
    endtask

    task automatic drain1();
        for (int i = 0; i < 600 && sb1.size() != 0; i++) step();
        checks++;
        if (sb1.size() != 0) begin
            errors++;
            $display("FAIL drain1_timeout: %0d keys pending, want 0", sb1.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        key_in1 = '0; key_valid1 = 1'b0; rk_ready1 = 1'b1;
        key_in4 = '0; key_valid4 = 1'b0; rk_ready4 = 1'b1;
        repeat (3) step();
        checks++;
        if ({key_ready1, rk_valid1, busy1, rk_round1, rk_out1} !== {3'b100, 4'd0, 128'd0}) begin
            errors++;
            $display("FAIL reset1: kr=%b v=%b busy=%b rnd=%0d out=%h, want 1 0 0 0 0",
                     key_ready1, rk_valid1, busy1, rk_round1, rk_out1);
        end
        checks++;
        if ({key_ready4, rk_valid4, busy4, rk_round4, rk_out4} !== {3'b100, 4'd0, 128'd0}) begin
            errors++;
            $display("FAIL reset4: kr=%b v=%b busy=%b rnd=%0d out=%h, want 1 0 0 0 0",
                     key_ready4, rk_valid4, busy4, rk_round4, rk_out4);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_fips();
        int bad = 0;
        clear1();
        rk_ready1 = 1'b1;
        key_in1 = FIPS_KEY;
        key_valid1 = 1'b1;
        step();
        key_valid1 = 1'b0;
        drain1();
        checks++;
        if (got1.size() != 11 || got1[0] !== FIPS_KEY || got1[1] !== FIPS_R1 || got1[10] !== FIPS_R10) begin
            errors++;
            $display("FAIL fips_vec: n=%0d r0=%h r1=%h r10=%h, want 11 %h %h %h",
                     got1.size(), got1[0], got1[1], got1[10], FIPS_KEY, FIPS_R1, FIPS_R10);
        end
        checks++;
        if (hs1[0] - acc1[0] !== 1) begin
            errors++;
            $display("FAIL fips_first: latency %0d, want 1", hs1[0] - acc1[0]);
        end
        for (int r = 1; r < 11; r++) if (hs1[r] - hs1[r-1] != 5) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL fips_spacing: %0d gaps not 5, want 0", bad);
        end
        checks++;
        if (hs1[10] - acc1[0] !== 51) begin
            errors++;
            $display("FAIL fips_total: %0d cycles, want 51", hs1[10] - acc1[0]);
        end
        checks++;
        if ({key_ready1, busy1, rk_valid1} !== 3'b100) begin
            errors++;
            $display("FAIL fips_idle: kr=%b busy=%b v=%b, want 1 0 0", key_ready1, busy1, rk_valid1);
        end
    endtask

    task automatic test_zero_wide();
        int bad = 0;
        got4.delete(); hs4.delete(); acc4.delete();
        key_in4 = '0;
        key_valid4 = 1'b1;
        step();
        key_valid4 = 1'b0;
        for (int i = 0; i < 300 && sb4.size() != 0; i++) step();
        checks++;
        if (sb4.size() != 0 || got4.size() != 11 || got4[1] !== ZERO_R1 || got4[10] !== ZERO_R10) begin
            errors++;
            $display("FAIL zero_vec: pend=%0d n=%0d r1=%h r10=%h, want 0 11 %h %h",
                     sb4.size(), got4.size(), got4[1], got4[10], ZERO_R1, ZERO_R10);
        end
        for (int r = 1; r < 11; r++) if (hs4[r] - hs4[r-1] != 2) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL zero_spacing: %0d gaps not 2, want 0", bad);
        end
        checks++;
        if (hs4[10] - acc4[0] !== 21) begin
            errors++;
            $display("FAIL zero_total: %0d cycles, want 21", hs4[10] - acc4[0]);
        end
    endtask

    task automatic test_backpressure();
        int stall = 0;
        clear1();
        key_in1 = {$urandom, $urandom, $urandom, $urandom};
        key_valid1 = 1'b1;
        step();
        key_valid1 = 1'b0;
        for (int i = 0; i < 600 && sb1.size() != 0; i++) begin
            if (rk_valid1 && rk_round1 == 4'd3 && stall < 7) begin
                rk_ready1 = 1'b0;
                stall++;
            end else begin
                rk_ready1 = 1'($urandom_range(0, 1));
            end
            step();
        end
        rk_ready1 = 1'b1;
        checks++;
        if (stall != 7 || sb1.size() != 0 || got1.size() != 11) begin
            errors++;
            $display("FAIL bp_stream: stall=%0d pend=%0d n=%0d, want 7 0 11",
                     stall, sb1.size(), got1.size());
        end
        step();
    endtask

    task automatic test_key_while_busy();
        int bad = 0;
        clear1();
        rk_ready1 = 1'b1;
        key_in1 = {$urandom, $urandom, $urandom, $urandom};
        key_valid1 = 1'b1;
        step();
        key_valid1 = 1'b0;
        repeat (20) step();
        key_in1 = FIPS_KEY;
        key_valid1 = 1'b1;
        for (int i = 0; i < 300 && acc1.size() < 2; i++) begin
            if (key_ready1 && hs1.size() < 11) bad++;
            step();
        end
        key_valid1 = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL busy_ready: key_ready high %0d cycles mid-stream, want 0", bad);
        end
        checks++;
        if (acc1.size() != 2 || hs1.size() != 11 || acc1[1] - hs1[10] != 1) begin
            errors++;
            $display("FAIL busy_accept: acc=%0d hs=%0d gap=%0d, want 2 11 1",
                     acc1.size(), hs1.size(), acc1[1] - hs1[10]);
        end
        drain1();
        checks++;
        if (got1.size() != 22 || got1[11] !== FIPS_KEY || got1[21] !== FIPS_R10) begin
            errors++;
            $display("FAIL busy_second: n=%0d r0=%h r10=%h, want 22 %h %h",
                     got1.size(), got1[11], got1[21], FIPS_KEY, FIPS_R10);
        end
    endtask

    task automatic test_reset_mid();
        int found = 0;
        int bad = 0;
        clear1();
        rk_ready1 = 1'b1;
        key_in1 = FIPS_KEY;
        key_valid1 = 1'b1;
        step();
        key_valid1 = 1'b0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            if (busy1 && !rk_valid1 && rk_round1 == 4'd5) found = 1;
            else step();
        end
        checks++;
        if (found == 0) begin
            errors++;
            $display("FAIL rst_mid_reach: round 5 SUB not seen, want seen");
        end
        rst = 1'b1;
        step();
        checks++;
        if ({key_ready1, rk_valid1, busy1, rk_round1, rk_out1} !== {3'b100, 4'd0, 128'd0}) begin
            errors++;
            $display("FAIL rst_mid_state: kr=%b v=%b busy=%b rnd=%0d out=%h, want 1 0 0 0 0",
                     key_ready1, rk_valid1, busy1, rk_round1, rk_out1);
        end
        rst = 1'b0;
        repeat (4) begin
            if (rk_valid1 !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rst_mid_quiet: rk_valid high %0d cycles, want 0", bad);
        end
        clear1();
        key_valid1 = 1'b1;
        step();
        key_valid1 = 1'b0;
        drain1();
        checks++;
        if (got1.size() != 11 || got1[1] !== FIPS_R1 || got1[10] !== FIPS_R10) begin
            errors++;
            $display("FAIL rst_mid_fresh: n=%0d r1=%h r10=%h, want 11 %h %h",
                     got1.size(), got1[1], got1[10], FIPS_R1, FIPS_R10);
        end
    endtask

    task automatic test_back_to_back();
        clear1();
        rk_ready1 = 1'b1;
        key_in1 = {$urandom, $urandom, $urandom, $urandom};
        key_valid1 = 1'b1;
        step();
        key_in1 = FIPS_KEY;
        for (int i = 0; i < 200 && acc1.size() < 2; i++) step();
        key_valid1 = 1'b0;
        checks++;
        if (acc1.size() != 2 || hs1.size() != 11 || acc1[1] - hs1[10] != 1 || acc1[1] - acc1[0] != 52) begin
            errors++;
            $display("FAIL b2b_accept: acc=%0d hs=%0d gap=%0d span=%0d, want 2 11 1 52",
                     acc1.size(), hs1.size(), acc1[1] - hs1[10], acc1[1] - acc1[0]);
        end
        drain1();
        checks++;
        if (got1.size() != 22 || got1[21] !== FIPS_R10) begin
            errors++;
            $display("FAIL b2b_streams: n=%0d last=%h, want 22 %h", got1.size(), got1[21], FIPS_R10);
        end
    endtask

    initial begin
        test_reset();
        test_fips();
        test_zero_wide();
        test_backpressure();
        test_key_while_busy();
        test_reset_mid();
        test_back_to_back();
        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
- Iterative AES-128 key-schedule controller.
- Accepts one 128-bit cipher key over a valid/ready handshake, then streams the 11 round keys (round 0..10) in order over a second valid/ready handshake.
- SubWord uses a time-shared S-box lookup built on aes_model_pack::SUB_BYTES_TABLE; Rcon comes from aes_model_pack::RCON_TABLE.
- Sits between key load logic and the AES round datapath or round-key storage.

Parameters:
- NUM_ROUNDS, 10, number of expansion rounds. Only 10 (AES-128) is supported; any other value is an elaboration error.
- SUB_BYTES_PER_CYCLE, 1, S-box lookups per cycle. Legal values are 1, 2 and 4. The number of SubWord cycles is SUB_CYCLES = 4 / SUB_BYTES_PER_CYCLE.

Ports:
- clk  input  1  single clock, all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- key_in  input  128  cipher key; [127:120] is key byte 0, w0 = [127:96], w3 = [31:0]
- key_valid  input  1  key_in is valid
- key_ready  output  1  block can accept a key
- rk_out  output  128  current round key, same byte order as key_in
- rk_round  output  4  index of rk_out, 0..10
- rk_valid  output  1  rk_out/rk_round are valid
- rk_ready  input  1  consumer accepts the round key
- busy  output  1  a key is being expanded

Behaviour:
- Clocking and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: state = IDLE, key_ready = 1, rk_valid = 0, busy = 0, rk_out = 0, rk_round = 0, sub counter = 0.
- Reset mid-operation: rst overrides everything. The expansion in flight is discarded and nothing further is emitted.
- IDLE:
  - key_ready = 1, busy = 0.
  - On key_valid && key_ready: latch key_in into rk_out, set rk_round = 0, go to EMIT.
- EMIT:
  - rk_valid = 1, busy = 1, key_ready = 0.
  - Under backpressure (rk_ready = 0), rk_out and rk_round must hold stable.
  - On rk_valid && rk_ready with rk_round == 10: go to IDLE. rk_out keeps its last value.
  - Otherwise, on handshake: go to SUB, clear the sub counter.
- SUB (SUB_CYCLES cycles):
  - rk_valid = 0, busy = 1.
  - Form rot = RotWord(w3) = {w3[23:16], w3[15:8], w3[7:0], w3[31:24]}.
  - Each cycle, substitute SUB_BYTES_PER_CYCLE bytes of rot, MSB byte first, into a 32-bit temp register.
  - On the last SUB cycle:
    - temp_f = SubWord(rot) XOR RCON_TABLE[rk_round] (index 0 = 32'h01000000).
    - w0' = w0 ^ temp_f; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
    - Write these into rk_out, increment rk_round, go to EMIT.
- Latency:
  - Key accept at edge t gives rk_valid for round 0 in cycle t+1.
  - A round-key handshake at edge t gives rk_valid for the next round in cycle t+1+SUB_CYCLES.
  - Full expansion with rk_ready held at 1 takes 11 + 10*SUB_CYCLES cycles from accept to the final handshake.
- key_valid during busy is ignored, since key_ready = 0. No key is queued.
- Back-to-back keys: in the cycle after the round-10 handshake, key_ready = 1 (IDLE). No bubble beyond that cycle is required.
- All arithmetic is bitwise XOR; there is no carry. rk_round never exceeds 10.
- Outputs are registered. key_ready and rk_valid are decoded directly from the state register.

Test Plan:
- FIPS-197 vector, SUB_BYTES_PER_CYCLE = 1, rk_ready = 1:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c.
  - Round 0 equals the key; round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Spacing is 5 cycles between valid rounds; accept to last handshake is 51 cycles.
- Zero key, SUB_BYTES_PER_CYCLE = 4:
  - Round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
  - Spacing is 2 cycles between valid rounds.
- Backpressure:
  - Stimulus: hold rk_ready = 0 for 7 cycles at round 3, with random rk_ready elsewhere.
  - rk_out and rk_round are stable while stalled; all 11 keys match the golden model, in order, with none dropped or duplicated.
- Key while busy:
  - Stimulus: assert key_valid with a different key during expansion.
  - key_ready stays 0, the current stream is unaffected, and the new key is accepted only after round 10.
- Reset mid-operation:
  - Stimulus: assert rst during SUB of round 5.
  - Next cycle: key_ready = 1, rk_valid = 0, busy = 0, rk_round = 0. A fresh FIPS key then expands correctly.
- Back-to-back:
  - Stimulus: two keys presented consecutively with key_valid held.
  - The second is accepted one cycle after the first stream's round-10 handshake, and both streams are correct.
